// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// A scoreboard slot records one in-flight destination between issue and write-back.
package pipe_pkg;

  localparam int ADDR_LEN_DEF  = 5;
  localparam int HAZ_DEPTH_DEF = 3;
  localparam int CNT_W_DEF     = 16;

  typedef struct packed {
    logic                    v;
    logic [ADDR_LEN_DEF-1:0] addr;
  } sb_slot_t;

  // A bubble carries no read and no write-back, so it never occupies the scoreboard.
  localparam logic     NOP_R_EN   = 1'b0;
  localparam logic     NOP_DST_WR = 1'b0;
  localparam sb_slot_t NOP_SLOT   = '{v: NOP_DST_WR, addr: '0};

endpackage

// File: rtl/hazard_cmp.sv
// Read-after-write match of one scoreboard slot against the sources of the
// instruction in ID; src2 only participates when the instruction reads it.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic                    slot_v,
  input  logic [ADDR_LEN_DEF-1:0] slot_addr,
  input  logic [ADDR_LEN_DEF-1:0] src1,
  input  logic [ADDR_LEN_DEF-1:0] src2,
  input  logic                    src2_used,
  output logic                    match
);

  assign match = slot_v & ((slot_addr == src1) | (src2_used & (slot_addr == src2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: scoreboard of pending destinations, RAW detection for ID,
// stall/bubble/issue generation and stall statistics.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_DEF,
  parameter int HAZ_DEPTH = HAZ_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 id_valid,
  input  logic [ADDR_LEN-1:0]  id_src1,
  input  logic [ADDR_LEN-1:0]  id_src2,
  input  logic                 id_src2_used,
  input  logic [ADDR_LEN-1:0]  id_dst,
  input  logic                 id_dst_wr,
  output logic                 stall,
  output logic                 bubble,
  output logic                 issue,
  output logic [HAZ_DEPTH-1:0] sb_valid,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 stall_err
);

  localparam int RUN_W = $clog2(HAZ_DEPTH + 2);

  sb_slot_t [HAZ_DEPTH-1:0] sb_pipe;
  logic     [HAZ_DEPTH-1:0] match;
  logic                     hazard;
  logic     [RUN_W-1:0]     run_cnt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] x);
    return (x == RUN_W'(HAZ_DEPTH + 1)) ? x : x + 1'b1;
  endfunction

  // Compare stage: every pending slot against the ID sources
  for (genvar i = 0; i < HAZ_DEPTH; i++) begin : g_cmp
    hazard_cmp u_cmp (
      .slot_v    (sb_pipe[i].v),
      .slot_addr (sb_pipe[i].addr),
      .src1      (id_src1),
      .src2      (id_src2),
      .src2_used (id_src2_used),
      .match     (match[i])
    );
    assign sb_valid[i] = sb_pipe[i].v;
  end

  assign hazard = id_valid & (|match);
  assign stall  = hazard;
  assign bubble = hazard;
  assign issue  = id_valid & ~hazard;

  // Scoreboard shift: keeps moving during a stall so pending writes drain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_pipe <= '0;
    end else begin
      sb_pipe[0] <= issue ? '{v: id_dst_wr, addr: id_dst} : NOP_SLOT;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_pipe[i] <= sb_pipe[i-1];
      end
    end
  end

  // Statistics: total stall cycles and the length of the current stall run
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
      stall_err <= 1'b0;
    end else begin
      if (stall) begin
        stall_cnt <= sat_inc_cnt(stall_cnt);
        run_cnt   <= sat_inc_run(run_cnt);
        if (run_cnt >= RUN_W'(HAZ_DEPTH)) stall_err <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a CNT_W=2 instance
// sharing the same ID stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       id_valid, id_src2_used, id_dst_wr;
  logic [4:0] id_src1, id_src2, id_dst;

  logic       stall, bubble, issue, stall_err;
  logic [2:0] sb_valid;
  logic [15:0] stall_cnt;

  logic       stall2, bubble2, issue2, stall_err2;
  logic [2:0] sb_valid2;
  logic [1:0] stall_cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  // Three valid slots all pointing at address 9
  logic [17:0] held = {3{6'b1_01001}};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_dst(id_dst), .id_dst_wr(id_dst_wr),
    .stall(stall), .bubble(bubble), .issue(issue), .sb_valid(sb_valid),
    .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src2_used(id_src2_used), .id_dst(id_dst), .id_dst_wr(id_dst_wr),
    .stall(stall2), .bubble(bubble2), .issue(issue2), .sb_valid(sb_valid2),
    .stall_cnt(stall_cnt2), .stall_err(stall_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_sbi(input string tag, input int s, input int i);
    chk({tag, ".stall"},  32'(stall),  s);
    chk({tag, ".bubble"}, 32'(bubble), s);
    chk({tag, ".issue"},  32'(issue),  i);
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic s2u, input logic [4:0] d, input logic dw);
    id_valid     = v;
    id_src1      = s1;
    id_src2      = s2;
    id_src2_used = s2u;
    id_dst       = d;
    id_dst_wr    = dw;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int s1_tab[3] = '{7, 8, 9};
    int s2_tab[3] = '{8, 9, 7};
    int sbv_tab[3] = '{1, 3, 7};

    // Reset state: issue follows id_valid, everything else cleared
    rstn = 1'b1;
    #1;
    rstn = 1'b0;
    drive(1, 3, 4, 1, 3, 1);
    chk_sbi("rst", 0, 1);
    chk("rst.sb_valid", 32'(sb_valid), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    chk("rst.err", 32'(stall_err), 0);
    drive(0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    tick();

    // Basic RAW on src1: 3 stall cycles, issue on the 4th
    drive(1, 0, 0, 0, 5, 1);
    chk_sbi("t1.c0", 0, 1);
    tick();
    drive(1, 5, 0, 0, 10, 1);
    for (int c = 1; c <= 3; c++) begin
      chk_sbi($sformatf("t1.c%0d", c), 1, 0);
      tick();
    end
    chk_sbi("t1.c4", 0, 1);
    chk("t1.cnt", 32'(stall_cnt), 3);
    chk("t1.err", 32'(stall_err), 0);
    tick();

    // Independent stream fills the scoreboard without stalling
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(s1_tab[k]), 5'(s2_tab[k]), 1, 5'(k + 1), 1);
      chk_sbi($sformatf("t2.c%0d", k), 0, 1);
      tick();
      chk($sformatf("t2.sbv%0d", k), 32'(sb_valid), sbv_tab[k]);
    end

    // src2 only matters when src2_used is set
    do_reset();
    tick();
    drive(1, 20, 0, 0, 4, 1);
    tick();
    drive(1, 2, 4, 0, 11, 0);
    chk_sbi("t3.unused", 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    drive(1, 20, 0, 0, 4, 1);
    tick();
    drive(1, 2, 4, 1, 11, 0);
    for (int c = 1; c <= 3; c++) begin
      chk_sbi($sformatf("t3.used.c%0d", c), 1, 0);
      tick();
    end
    chk_sbi("t3.used.c4", 0, 1);
    chk("t3.cnt", 32'(stall_cnt), 3);

    // Producer without write-back leaves nothing pending
    do_reset();
    tick();
    drive(1, 20, 0, 0, 6, 0);
    tick();
    chk("t4.sbv", 32'(sb_valid), 0);
    drive(1, 6, 0, 0, 12, 0);
    chk_sbi("t4.cons", 0, 1);

    // Four dependent pairs: 12 stall cycles, narrow counter saturates at 3
    do_reset();
    tick();
    for (int p = 0; p < 4; p++) begin
      drive(1, 20, 0, 0, 5'(p + 1), 1);
      tick();
      drive(1, 5'(p + 1), 0, 0, 0, 0);
      for (int c = 1; c <= 3; c++) begin
        if (p == 0) chk($sformatf("t5.stall2.c%0d", c), 32'(stall2), 1);
        tick();
      end
      if (p == 0) begin
        chk("t5.cnt2.first", 32'(stall_cnt2), 3);
        chk("t5.issue2", 32'(issue2), 1);
        chk("t5.bubble2", 32'(bubble2), 0);
      end
      tick();
    end
    chk("t5.cnt", 32'(stall_cnt), 12);
    chk("t5.cnt2.sat", 32'(stall_cnt2), 3);
    chk("t5.sbv2", 32'(sb_valid2), 0);

    // Reset in the middle of a stall
    do_reset();
    tick();
    drive(1, 20, 0, 0, 5, 1);
    tick();
    drive(1, 5, 0, 0, 13, 1);
    chk_sbi("t6.c1", 1, 0);
    tick();
    chk_sbi("t6.c2", 1, 0);
    chk("t6.cnt.pre", 32'(stall_cnt), 1);
    rstn = 1'b0;
    #1;
    chk_sbi("t6.rst", 0, 1);
    chk("t6.sbv", 32'(sb_valid), 0);
    chk("t6.cnt", 32'(stall_cnt), 0);
    #1;
    rstn = 1'b1;
    chk("t6.rel.issue", 32'(issue), 1);
    tick();
    chk("t6.sbv.after", 32'(sb_valid), 1);

    // Frozen scoreboard: stall_err rises on the 4th consecutive stall and sticks
    do_reset();
    tick();
    force dut.sb_pipe = held;
    drive(1, 9, 0, 0, 14, 1);
    chk("t7.stall", 32'(stall), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t7.err.k%0d", k), 32'(stall_err), (k >= 4) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t7.err.sticky", 32'(stall_err), 1);
    release dut.sb_pipe;
    do_reset();
    chk("t7.err.rst", 32'(stall_err), 0);
    chk("t7.err2", 32'(stall_err2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage IF/ID/MEM/ALU/WB processor.
- Keeps a scoreboard of destination addresses for operations still in flight between issue and write-back.
- Detects read-after-write hazards for the instruction sitting in ID.
- On a hazard, freezes IF and the IF/ID buffer and injects a bubble into the ID-to-MEM registers.
- Provides stall statistics and a sticky protocol-error flag for debug.

Parameters:
ADDR_LEN, 5, register/memory address width
HAZ_DEPTH, 3, number of stages an issued destination stays pending (MEM read, ALU, WB)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src1  in  ADDR_LEN  first source address (always used)
id_src2  in  ADDR_LEN  second source address
id_src2_used  in  1  id_src2 is read by this instruction
id_dst  in  ADDR_LEN  destination address
id_dst_wr  in  1  instruction writes id_dst in WB
stall  out  1  hold PC and IF/ID buffer this cycle
bubble  out  1  load a NOP (r_en=0, dst_wr=0) into the ID/MEM registers
issue  out  1  instruction in ID advances this cycle
sb_valid  out  HAZ_DEPTH  valid bit of each scoreboard slot
stall_cnt  out  CNT_W  total stall cycles, saturating
stall_err  out  1  sticky: stall exceeded HAZ_DEPTH consecutive cycles

Behaviour:
- Scoreboard slots s[0..HAZ_DEPTH-1], each holding {v, addr}. s[0] is the instruction issued in the previous cycle.
- Every rising edge the scoreboard shifts:
  - s[0] <= issue ? {id_dst_wr, id_dst} : {0, 0}.
  - s[i] <= s[i-1] for i >= 1.
  - s[HAZ_DEPTH-1] retires.
  - Shifting continues during a stall; bubbles enter as invalid slots.
- Hazard condition (combinational): hazard = id_valid AND, for some i, s[i].v AND (s[i].addr == id_src1 OR (id_src2_used AND s[i].addr == id_src2)).
- Outputs (combinational, same cycle):
  - stall = hazard
  - bubble = hazard
  - issue = id_valid AND NOT hazard
  - When id_valid=0, all three are 0. No bubble is needed because ID already carries no instruction.
- Address 0 gets no special treatment.
- Dependency latency: producer issued in cycle t, dependent consumer in ID at t+1:
  - stall is high during t+1 .. t+HAZ_DEPTH.
  - The consumer issues at t+HAZ_DEPTH+1.
- An instruction whose own src equals its own dst does not self-stall, since its dst is not yet in the scoreboard.
- A matching source is compared only when id_src2_used=1; the id_src2 value is ignored otherwise.
- Multiple matching slots: stall lasts until the youngest matching slot retires.
- stall_cnt:
  - Increments by 1 on every edge where stall=1.
  - Holds at 2^CNT_W-1 and never wraps.
- Consecutive-stall counter:
  - Internal, width ceil(log2(HAZ_DEPTH+2)).
  - Clears on any cycle with stall=0.
  - stall_err is set when it would exceed HAZ_DEPTH, and is cleared only by reset.
- Reset (asserted at any time, including mid-stall):
  - All slots invalid, sb_valid=0, stall_cnt=0, stall_err=0, consecutive counter=0.
  - stall, bubble and issue then follow only id_valid, so issue=id_valid.
  - In-flight operations are discarded; the whole pipeline resets together.
- Release of rstn takes effect asynchronously; the first shift happens on the first rising clk after release.

Decomposition:
- Shared package pipe_pkg:
  - ADDR_LEN, HAZ_DEPTH, CNT_W defaults
  - sb_slot_t typedef {logic v; logic [ADDR_LEN-1:0] addr}
  - NOP encoding constants used by bubble insertion
- One natural sub-module: hazard_cmp. It takes one slot plus src1, src2 and src2_used and outputs a match bit. It is instantiated HAZ_DEPTH times, and the results are OR-reduced in pipe_hazard_ctrl.

Test Plan:
- Issue dst=5 wr=1 at cycle 0, then src1=5 at cycle 1 -> stall=bubble=1 in cycles 1-3, issue=1 in cycle 4, stall_cnt=3, stall_err=0.
- Independent stream (dst 1,2,3; srcs 7,8,9) -> stall never 1, issue every cycle, sb_valid reaches 3'b111.
- Producer dst=4 wr=1, consumer src1=2, src2=4, src2_used=0 -> no stall. Same with src2_used=1 -> 3-cycle stall.
- Producer dst=6 with id_dst_wr=0, consumer src1=6 -> no stall, sb_valid[0]=0 after issue.
- CNT_W=2, four dependent pairs (12 stall cycles) -> stall_cnt saturates at 3 and stays 3.
- rstn pulsed low in cycle 2 of a 3-cycle stall -> sb_valid=0, stall=0, issue=id_valid immediately, stall_cnt=0.
- Force the scoreboard held (shift disabled by bench) -> stall_err rises on the 4th consecutive stall cycle and stays 1 until reset.
